// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_ACK   = 8'hFA;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int ps2_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO for received scan codes.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin sync, frame deframing/checking, scan-code FIFO.
// Optional PS2_GLITCH_FILTER_EN adds a FILTER_LEN-sample debounce on the clock pin.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               PS2_clk,
    input  logic                               PS2_Data,
    input  logic                               ps2_rd,
    input  logic                               ovf_clr,
    output logic                               ps2_ready,
    output logic [7:0]                         key,
    output logic [31:0]                        key_d,
    output logic [ps2_cnt_w(FIFO_DEPTH)-1:0]   count,
    output logic                               frame_err,
    output logic                               overflow
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic fclk, fclk_prev_q, fall, din;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            fclk_prev_q <= 1'b1;
        end else begin
            clk_s1_q    <= PS2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= PS2_Data;
            dat_s2_q    <= dat_s1_q;
            fclk_prev_q <= fclk;
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic          filt_q;
    logic [FW-1:0] filt_cnt_q;

    // Level flips only once FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s2_q == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q     <= clk_s2_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end
    assign fclk = filt_q;
`else
    assign fclk = clk_s2_q;
`endif

    assign fall = fclk_prev_q & ~fclk;
    assign din  = dat_s2_q;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    code_q, code_d;
    logic          push_q, push_d;
    logic          err_d;
    logic          frame_err_q;
    logic          overflow_q;
    logic [31:0]   key_d_q;
    logic          fifo_full, fifo_empty, drop;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        code_d   = code_q;
        push_d   = 1'b0;
        err_d    = 1'b0;
        to_cnt_d = (fall || state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;
        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!din) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {din, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = din;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (din && (^{shreg_q, par_q})) begin
                        push_d = 1'b1;
                        code_d = shreg_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            // Stalled keyboard: drop the partial frame so the next start bit resyncs.
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    assign drop = push_q & fifo_full & ~ps2_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            code_q      <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            key_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            code_q      <= code_d;
            push_q      <= push_d;
            frame_err_q <= err_d;
            if (drop)         overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
            // History records every valid code, even one the full FIFO drops.
            if (push_q)       key_d_q <= {key_d_q[23:0], code_q};
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (ps2_rd),
        .wdata (code_q),
        .rdata (key),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign ps2_ready = ~fifo_empty;
    assign key_d     = key_d_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx (both filter builds).
module tb_ps2_kbd_rx;

    localparam int FD = 8;
    localparam int FL = 8;
    localparam int TO = 1000;
    localparam int H  = 20;
`ifdef PS2_GLITCH_FILTER_EN
    localparam int LAT = 3 + FL;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PS2_clk = 1'b1;
    logic        PS2_Data = 1'b1;
    logic        ps2_rd = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        ps2_ready;
    logic [7:0]  key;
    logic [31:0] key_d;
    logic [3:0]  count;
    logic        frame_err;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;
    int err_pulses = 0;
    int err_consec = 0;
    logic err_prev = 1'b0;
    int e0;

    ps2_kbd_rx #(
        .FIFO_DEPTH  (FD),
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PS2_clk   (PS2_clk),
        .PS2_Data  (PS2_Data),
        .ps2_rd    (ps2_rd),
        .ovf_clr   (ovf_clr),
        .ps2_ready (ps2_ready),
        .key       (key),
        .key_d     (key_d),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) begin
            err_pulses++;
            if (err_prev) err_consec++;
        end
        err_prev = frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One PS/2 bit; optionally raise ps2_rd exactly in the push cycle after this fall.
    task automatic ps2_bit(input logic b, input bit rd_on_push);
        @(negedge clk) PS2_Data = b;
        repeat (H) @(negedge clk);
        PS2_clk = 1'b0;
        if (rd_on_push) begin
            repeat (LAT) @(posedge clk);
            @(negedge clk) ps2_rd = 1'b1;
            @(negedge clk) ps2_rd = 1'b0;
            repeat (H - LAT - 2) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
        PS2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit rd_on_push);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i], rd_on_push && (i == 10));
        repeat (H) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk) ps2_rd = 1'b1;
        @(negedge clk) ps2_rd = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, ps2_ready}, 32'd0);
        chk({tag, "_key"}, {24'd0, key}, 32'd0);
        chk({tag, "_key_d"}, key_d, 32'd0);
        chk({tag, "_count"}, {28'd0, count}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Test 1: valid 0x1C
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("t1_ready", {31'd0, ps2_ready}, 32'd1);
        chk("t1_key", {24'd0, key}, 32'h1C);
        chk("t1_count", {28'd0, count}, 32'd1);
        chk("t1_key_d", key_d, 32'h0000001C);
        chk("t1_frame_err", {31'd0, frame_err}, 32'd0);
        pop_one();
        chk("t1_ready_after_pop", {31'd0, ps2_ready}, 32'd0);

        // Test 2: parity error
        e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("t2_err_pulses", err_pulses - e0, 32'd1);
        chk("t2_ready", {31'd0, ps2_ready}, 32'd0);
        chk("t2_key_d", key_d, 32'h0000001C);

        // Test 3: overflow with nine frames
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("t3_count", {28'd0, count}, 32'd8);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_key", {24'd0, key}, 32'h01);
        chk("t3_key_d", key_d, 32'h06070809);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t3_pop%0d", i), {24'd0, key}, 32'(i));
            pop_one();
        end
        chk("t3_ready_empty", {31'd0, ps2_ready}, 32'd0);
        chk("t3_count_empty", {28'd0, count}, 32'd0);
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        chk("t3_ovf_clr", {31'd0, overflow}, 32'd0);

        // Test 4: timeout on a partial frame
        e0 = err_pulses;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        repeat (TO + 10) @(negedge clk);
        chk("t4_timeout_err", err_pulses - e0, 32'd1);
        send_frame(8'hF0, 1'b0, 1'b0);
        chk("t4_key", {24'd0, key}, 32'hF0);
        chk("t4_count", {28'd0, count}, 32'd1);
        pop_one();

        // Test 5: simultaneous push/pop while full
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0);
        chk("t5_full_count", {28'd0, count}, 32'd8);
        send_frame(8'hAA, 1'b0, 1'b1);
        chk("t5_count", {28'd0, count}, 32'd8);
        chk("t5_overflow", {31'd0, overflow}, 32'd0);
        chk("t5_head", {24'd0, key}, 32'h12);
        for (int i = 0; i < 7; i++) pop_one();
        chk("t5_aa", {24'd0, key}, 32'hAA);
        chk("t5_count_last", {28'd0, count}, 32'd1);

        // Reset mid-frame
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h33, 1'b0, 1'b0);
        chk("midrst_key", {24'd0, key}, 32'h33);
        chk("midrst_count", {28'd0, count}, 32'd1);
        pop_one();

`ifdef PS2_GLITCH_FILTER_EN
        // Test 6: short clock glitch must not start a frame
        e0 = err_pulses;
        @(negedge clk) PS2_Data = 1'b0;
        PS2_clk = 1'b0;
        repeat (3) @(negedge clk);
        PS2_clk = 1'b1;
        repeat (30) @(negedge clk);
        PS2_Data = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("t6_key", {24'd0, key}, 32'h5A);
        chk("t6_count", {28'd0, count}, 32'd1);
        chk("t6_no_err", err_pulses - e0, 32'd0);
`endif

        chk("err_never_consecutive", err_consec, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
